fmrom_loader: RTL
=================

Name: fmrom_loader

Overview:
- Write-side initiator for the 16 KiB synchronous FM/OPL sound memory (1-cycle read latency, write-enable port).
- Fills the memory sequentially from a byte stream, such as a flash/UART boot path, then reads every location back and checks a checksum.
- Outside a load it passes the CPU/sound-engine address through to the memory unchanged.
- Sits between the boot-stream source, the memory's address/data/wren/q pins, and the FM engine's address bus.

Parameters:
- ADDR_W, 14, memory address width.
- DEPTH, 16384, number of bytes loaded and verified; must equal 2**ADDR_W.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERROR.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader accepts the byte this cycle.
- cpu_address  in  ADDR_W  address from the FM engine, passed through when not busy.
- mem_address  out  ADDR_W  to memory address.
- mem_data  out  8  to memory write data.
- mem_wren  out  1  to memory write enable.
- mem_q  in  8  memory read data, valid one clock after the address.
- busy  out  1  high in LOAD and VERIFY.
- done  out  1  sticky; verify passed.
- error  out  1  sticky; verify checksum mismatch.
- checksum  out  16  load-side checksum: the 16-bit wrapping sum of all bytes written.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; wr_ptr, rd_ptr, sum_w and sum_r are 0; rd_pending=0.
  - s_ready=0, mem_wren=0, busy=0, done=0, error=0, checksum=0.
  - mem_address=cpu_address (combinational pass-through).
- Output muxing is combinational from the state:
  - IDLE/DONE/ERROR: mem_address=cpu_address, mem_wren=0, mem_data=0.
  - LOAD: mem_address=wr_ptr, mem_data=s_data, mem_wren=s_valid, s_ready=1.
  - VERIFY: mem_address=rd_ptr, mem_wren=0, s_ready=0.
- IDLE/DONE/ERROR, start=1:
  - next state LOAD; wr_ptr=0, sum_w=0; done and error cleared.
  - The load always covers DEPTH bytes.
- LOAD:
  - Each cycle with s_valid=1 writes one byte.
  - sum_w += s_data (mod 2^16); wr_ptr++.
  - When the byte at wr_ptr=DEPTH-1 is accepted, the next state is VERIFY, with rd_ptr=0 and sum_r=0.
  - Gaps in s_valid stall the load indefinitely; there is no timeout.
- VERIFY:
  - rd_ptr increments every cycle from 0 to DEPTH-1, one read issued per cycle.
  - rd_pending is a 1-cycle delayed issue flag. When it is set, sum_r += mem_q.
  - The last address is issued at cycle DEPTH-1. Its data is captured the following cycle; at that point compare sum_r (including the last byte) with sum_w.
  - Equal: state DONE, done=1. Not equal: state ERROR, error=1.
  - VERIFY lasts DEPTH+1 cycles.
- checksum register updates to sum_w on entry to VERIFY and holds until the next start.
- start while busy is ignored; no restart and no abort.
- Pointer widths are ADDR_W.
  - Terminal detection uses an explicit compare against DEPTH-1, not pointer wrap.
  - The pointer wraps to 0 afterwards, which is harmless.
- s_valid asserted outside LOAD is ignored; s_ready=0 there, so no byte is consumed.
- Reset during LOAD or VERIFY returns to IDLE; the memory contents are partial and undefined.
- busy = (state==LOAD or VERIFY).

Decomposition:
- Shared package holds:
  - state encoding: IDLE, LOAD, VERIFY, DONE, ERROR;
  - FMROM_ADDR_W=14 and FMROM_DEPTH=16384;
  - checksum width 16.
- No sub-module is needed.
- The checksum accumulator is a small natural helper, fmrom_sum16: 16-bit wrapping add with clear, used twice (write and read side). Optional.

Test Plan (bench instantiates the loader wired to a behavioural 16K sync RAM with 1-cycle read latency):
- Reset values: hold reset_n=0, drive cpu_address=0x0ABC -> mem_address=0x0ABC, mem_wren=0, s_ready=0, busy=done=error=0.
- Full load without stalls: start, then stream bytes (i mod 256) for i=0..16383 with s_valid=1 continuously -> checksum=0xE000. After 16385 VERIFY cycles done=1, error=0, and RAM[0x1234]=0x34.
- Backpressure: the same stream with s_valid low for 3 cycles after every 7th byte -> identical RAM contents, checksum=0xE000, done=1, and no byte duplicated or skipped.
- Fault injection: the RAM model returns the stored byte XOR 0x01 at address 0x1234 during VERIFY -> error=1, done=0, state ERROR. A fresh start then clears error.
- start pulsed while busy in the middle of LOAD (at byte 100) -> ignored; the load continues to byte 16383 and done=1. Reset asserted at byte 5000 -> busy=0 and done=0 immediately (asynchronously).
- Pass-through after DONE: cpu_address=0x0005 -> mem_address=0x0005 the same cycle, and mem_q=0x05 on the next clock.

Source files
------------

// File: rtl/fmrom_loader_pkg.sv
// Shared types and constants for the FM sound-memory boot loader.
// Holds the loader state encoding, memory geometry and the checksum accumulator.
package fmrom_loader_pkg;

  localparam int FMROM_ADDR_W = 14;
  localparam int FMROM_DEPTH  = 16384;
  localparam int FMROM_SUM_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } fmrom_state_e;

  // 16-bit wrapping byte sum with clear; shared by the write and read sides.
  function automatic logic [FMROM_SUM_W-1:0] fmrom_sum16(
    input logic [FMROM_SUM_W-1:0] acc_i,
    input logic [7:0]             data_i,
    input logic                   clr_i
  );
    logic [FMROM_SUM_W-1:0] res;
    if (clr_i) begin
      res = {FMROM_SUM_W{1'b0}};
    end else begin
      res = acc_i + {{(FMROM_SUM_W-8){1'b0}}, data_i};
    end
    return res;
  endfunction

endpackage

// File: rtl/fmrom_loader.sv
// Boot loader for the 16 KiB FM/OPL sound memory: streams bytes in, reads them
// back, compares checksums, and otherwise passes the FM engine address through.
module fmrom_loader
  import fmrom_loader_pkg::*;
#(
  parameter int ADDR_W = FMROM_ADDR_W,
  parameter int DEPTH  = FMROM_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ADDR_W-1:0]      cpu_address,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [7:0]             mem_data,
  output logic                   mem_wren,
  input  logic [7:0]             mem_q,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [FMROM_SUM_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  fmrom_state_e           state_q, state_d;
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FMROM_SUM_W-1:0] sum_w_q, sum_w_d;
  logic [FMROM_SUM_W-1:0] sum_r_q, sum_r_d;
  logic [FMROM_SUM_W-1:0] checksum_q, checksum_d;
  logic                   rd_pending_q, rd_pending_d;
  logic                   rd_last_q, rd_last_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [FMROM_SUM_W-1:0] sum_fin_s;

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sum_w_q      <= '0;
      sum_r_q      <= '0;
      checksum_q   <= '0;
      rd_pending_q <= 1'b0;
      rd_last_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sum_w_q      <= sum_w_d;
      sum_r_q      <= sum_r_d;
      checksum_q   <= checksum_d;
      rd_pending_q <= rd_pending_d;
      rd_last_q    <= rd_last_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Next-state logic and memory-side output muxing.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sum_w_d      = sum_w_q;
    sum_r_d      = sum_r_q;
    checksum_d   = checksum_q;
    rd_pending_d = 1'b0;
    rd_last_d    = rd_last_q;
    done_d       = done_q;
    error_d      = error_q;
    mem_address  = cpu_address;
    mem_data     = 8'h00;
    mem_wren     = 1'b0;
    s_ready      = 1'b0;
    sum_fin_s    = fmrom_sum16(sum_r_q, mem_q, 1'b0);

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          sum_w_d  = fmrom_sum16(sum_w_q, 8'h00, 1'b1);
          done_d   = 1'b0;
          error_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      ST_LOAD: begin
        mem_address = wr_ptr_q;
        mem_data    = s_data;
        mem_wren    = s_valid;
        s_ready     = 1'b1;
        if (s_valid) begin
          sum_w_d  = fmrom_sum16(sum_w_q, s_data, 1'b0);
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          // Terminal count by compare, so the pointer may wrap afterwards.
          if (wr_ptr_q == LAST_ADDR) begin
            state_d    = ST_VERIFY;
            rd_ptr_d   = '0;
            sum_r_d    = fmrom_sum16(sum_r_q, 8'h00, 1'b1);
            rd_last_d  = 1'b0;
            checksum_d = sum_w_d;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_VERIFY: begin
        mem_address = rd_ptr_q;
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        if (rd_pending_q) begin
          sum_r_d = sum_fin_s;
        end else begin
          sum_r_d = sum_r_q;
        end
        // rd_last_q marks the extra cycle that catches the final read's data.
        if (rd_last_q) begin
          if (sum_fin_s == sum_w_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end else begin
          rd_pending_d = 1'b1;
          rd_last_d    = (rd_ptr_q == LAST_ADDR);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
  assign done     = done_q;
  assign error    = error_q;
  assign checksum = checksum_q;

endmodule
